// File: rtl/apb_ram_slave_pkg.sv
// Shared types and helpers for the APB4 RAM completer.
package apb_ram_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RDDATA = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam int PPROT_NONSEC = 1;

    // Byte size of the decoded window; 33 bits so a 4 GiB window still fits.
    function automatic logic [32:0] window_bytes(input int addr_bits);
        return 33'd4 << addr_bits;
    endfunction

endpackage

// File: rtl/apb_ram_slave.sv
// APB4 completer in front of a synchronous single-port word RAM, with wait
// states, byte strobes, error responses, error counter and protocol flag.
module apb_ram_slave
    import apb_ram_slave_pkg::*;
#(
    parameter int          ADDR_BITS   = 10,
    parameter int          DATA_BITS   = 32,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter bit          PROT_CHECK  = 1'b1
) (
    input  logic                 apb_clock,
    input  logic                 resetn,
    input  logic                 apb_psel,
    input  logic                 apb_penable,
    input  logic                 apb_pwrite,
    input  logic [31:0]          apb_paddr,
    input  logic [DATA_BITS-1:0] apb_pwdata,
    input  logic [3:0]           apb_pstrb,
    input  logic [2:0]           apb_pprot,
    output logic                 apb_pready,
    output logic                 apb_pslverr,
    output logic [DATA_BITS-1:0] apb_prdata,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [3:0]           ram_byteena,
    output logic [31:0]          ram_data,
    output logic                 ram_wren,
    output logic                 ram_rden,
    input  logic [31:0]          ram_q,
    output logic [15:0]          err_count,
    output logic                 proto_err
);

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   write_q, write_d;
    logic                   err_q, err_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_BITS-1:0]   wdata_q, wdata_d;
    logic [3:0]             byteena_q, byteena_d;
    logic [DATA_BITS-1:0]   prdata_q, prdata_d;
    logic [15:0]            err_count_q, err_count_d;
    logic                   proto_err_q, proto_err_d;

    logic [31:0] offset;
    logic        setup_err;
    logic        unused_prot;

    // Offsets below BASE_ADDR wrap to huge values and fall out of range.
    assign offset    = apb_paddr - BASE_ADDR;
    assign setup_err = (apb_paddr[1:0] != 2'b00)
                    || ({1'b0, offset} >= window_bytes(ADDR_BITS))
                    || (PROT_CHECK && apb_pprot[PPROT_NONSEC]);
    assign unused_prot = ^{apb_pprot[2], apb_pprot[0]};

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        err_d       = err_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        byteena_d   = byteena_q;
        prdata_d    = prdata_q;
        err_count_d = err_count_q;
        proto_err_d = proto_err_q;
        ram_wren    = 1'b0;
        ram_rden    = 1'b0;
        apb_pready  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (apb_psel && !apb_penable) begin
                    write_d   = apb_pwrite;
                    err_d     = setup_err;
                    addr_d    = offset[ADDR_BITS+1:2];
                    wdata_d   = apb_pwdata;
                    byteena_d = apb_pwrite ? apb_pstrb : 4'hf;
                    prdata_d  = '0;
                    cnt_d     = 4'(WAIT_CYCLES);
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!apb_psel) begin
                    proto_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (err_q) begin
                    state_d = ST_RESP;
                end else if (write_q) begin
                    ram_wren = |byteena_q;
                    state_d  = ST_RESP;
                end else begin
                    ram_rden = 1'b1;
                    state_d  = ST_RDDATA;
                end
            end
            ST_RDDATA: begin
                if (!apb_psel) begin
                    proto_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    prdata_d = ram_q;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                apb_pready = 1'b1;
                if (err_q && err_count_q != 16'hFFFF) begin
                    err_count_d = err_count_q + 16'd1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge apb_clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            byteena_q   <= '0;
            prdata_q    <= '0;
            err_count_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            byteena_q   <= byteena_d;
            prdata_q    <= prdata_d;
            err_count_q <= err_count_d;
            proto_err_q <= proto_err_d;
        end
    end

    // prdata_q is cleared at setup and only loaded on a good read.
    assign apb_pslverr = apb_pready && err_q;
    assign apb_prdata  = apb_pready ? prdata_q : '0;
    assign ram_addr    = addr_q;
    assign ram_byteena = byteena_q;
    assign ram_data    = wdata_q;
    assign err_count   = err_count_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_apb_ram_slave.sv
// Directed bench for apb_ram_slave with a behavioural RAM model; latencies
// are counted in cycles from the setup cycle (T0).
module tb_apb_ram_slave;
    import apb_ram_slave_pkg::*;

    logic        apb_clock = 1'b0;
    logic        resetn;
    logic        apb_psel, apb_penable, apb_pwrite;
    logic [31:0] apb_paddr, apb_pwdata;
    logic [3:0]  apb_pstrb;
    logic [2:0]  apb_pprot;
    logic        apb_pready, apb_pslverr;
    logic [31:0] apb_prdata;
    logic [9:0]  ram_addr;
    logic [3:0]  ram_byteena;
    logic [31:0] ram_data;
    logic        ram_wren, ram_rden;
    logic [31:0] ram_q;
    logic [15:0] err_count;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    int          wr_cyc, rd_cyc, rdy_cyc, n_wren, n_rden;
    logic        got_err;
    logic [31:0] got_rdata, seen_data;
    logic [3:0]  seen_be;
    logic [9:0]  seen_addr;

    logic [31:0] mem [0:1023];

    apb_ram_slave #(
        .ADDR_BITS(10), .DATA_BITS(32), .WAIT_CYCLES(2),
        .BASE_ADDR(32'h0), .PROT_CHECK(1'b1)
    ) dut (
        .apb_clock(apb_clock), .resetn(resetn),
        .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
        .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_pstrb(apb_pstrb),
        .apb_pprot(apb_pprot), .apb_pready(apb_pready), .apb_pslverr(apb_pslverr),
        .apb_prdata(apb_prdata), .ram_addr(ram_addr), .ram_byteena(ram_byteena),
        .ram_data(ram_data), .ram_wren(ram_wren), .ram_rden(ram_rden),
        .ram_q(ram_q), .err_count(err_count), .proto_err(proto_err)
    );

    always #5 apb_clock = ~apb_clock;

    // Synchronous RAM: byte-enabled write, read data one cycle after rden.
    always @(posedge apb_clock) begin
        if (ram_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_byteena[b]) mem[ram_addr][8*b +: 8] <= ram_data[8*b +: 8];
            end
        end
        if (ram_rden) ram_q <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; that cycle is T0. Returns once the IDLE cycle after pready begins.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot);
        apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = wr;
        apb_paddr = addr; apb_pwdata = wdata; apb_pstrb = strb; apb_pprot = prot;
        wr_cyc = -1; rd_cyc = -1; rdy_cyc = -1; n_wren = 0; n_rden = 0;
        got_err = 1'b0; got_rdata = '0; seen_be = '0; seen_addr = '0; seen_data = '0;
        for (int t = 0; t < 16 && rdy_cyc < 0; t++) begin
            @(negedge apb_clock);
            if (ram_wren) begin
                wr_cyc = t; n_wren++;
                seen_be = ram_byteena; seen_addr = ram_addr; seen_data = ram_data;
            end
            if (ram_rden) begin
                rd_cyc = t; n_rden++;
                seen_be = ram_byteena; seen_addr = ram_addr;
            end
            if (apb_pready) begin
                rdy_cyc = t; got_err = apb_pslverr; got_rdata = apb_prdata;
            end
            @(posedge apb_clock); #1;
            apb_penable = 1'b1;
        end
        apb_psel = 1'b0; apb_penable = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
        apb_paddr = '0; apb_pwdata = '0; apb_pstrb = '0; apb_pprot = '0;
        repeat (3) @(posedge apb_clock);
        @(negedge apb_clock);
        chk("reset_apb_outs", {apb_pready, apb_pslverr, apb_prdata}, 64'h0);
        chk("reset_ram_ctl", {ram_wren, ram_rden, ram_addr, ram_byteena}, 64'h0);
        chk("reset_ram_data", {32'h0, ram_data}, 64'h0);
        chk("reset_status", {err_count, proto_err}, 64'h0);
        resetn = 1'b1;
        @(posedge apb_clock); #1;

        // Full-word write: wren at T3, pready at T4.
        apb_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hf, 3'b000);
        chk("wr_wren_cycle", wr_cyc, 3);
        chk("wr_ram_addr", seen_addr, 10'd4);
        chk("wr_byteena", seen_be, 4'hf);
        chk("wr_ram_data", seen_data, 32'hDEADBEEF);
        chk("wr_ready_cycle", rdy_cyc, 4);
        chk("wr_slverr", got_err, 1'b0);

        // Read back: rden at T3, pready at T5.
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b000);
        chk("rd_rden_cycle", rd_cyc, 3);
        chk("rd_byteena", seen_be, 4'hf);
        chk("rd_ready_cycle", rdy_cyc, 5);
        chk("rd_data", got_rdata, 32'hDEADBEEF);
        chk("rd_slverr", got_err, 1'b0);
        chk("rd_no_wren", n_wren, 0);

        // Misaligned and out-of-range writes.
        apb_xfer(1'b1, 32'h12, 32'h12345678, 4'hf, 3'b000);
        chk("misalign_wren", n_wren, 0);
        chk("misalign_slverr", got_err, 1'b1);
        chk("misalign_ready", rdy_cyc, 4);
        apb_xfer(1'b1, 32'h1000, 32'h12345678, 4'hf, 3'b000);
        chk("range_wren", n_wren, 0);
        chk("range_slverr", got_err, 1'b1);
        chk("err_count_2", err_count, 16'd2);

        // Non-secure read rejected, secure-but-privileged read accepted.
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b011);
        chk("nonsec_slverr", got_err, 1'b1);
        chk("nonsec_rdata", got_rdata, 32'h0);
        chk("nonsec_rden", n_rden, 0);
        chk("nonsec_ready", rdy_cyc, 4);
        chk("err_count_3", err_count, 16'd3);
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b001);
        chk("sec_slverr", got_err, 1'b0);
        chk("sec_rdata", got_rdata, 32'hDEADBEEF);

        // Byte strobes: AABBCCDD overlaid with 11223344 on lanes 0 and 2.
        apb_xfer(1'b1, 32'h20, 32'hAABBCCDD, 4'hf, 3'b000);
        apb_xfer(1'b1, 32'h20, 32'h11223344, 4'b0101, 3'b000);
        chk("strb_byteena", seen_be, 4'b0101);
        chk("strb_wren", n_wren, 1);
        apb_xfer(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 3'b000);
        chk("strb0_wren", n_wren, 0);
        chk("strb0_slverr", got_err, 1'b0);
        chk("strb0_ready", rdy_cyc, 4);
        apb_xfer(1'b0, 32'h20, 32'h0, 4'h0, 3'b000);
        chk("strb_readback", got_rdata, 32'hAA22CC44);
        chk("proto_err_clear", proto_err, 1'b0);

        // Drop psel during the wait phase (T2).
        apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b1;
        apb_paddr = 32'h30; apb_pwdata = 32'h55555555; apb_pstrb = 4'hf; apb_pprot = 3'b000;
        @(posedge apb_clock); #1;
        apb_penable = 1'b1;
        @(posedge apb_clock); #1;
        apb_psel = 1'b0; apb_penable = 1'b0;
        @(negedge apb_clock);
        chk("abort_t2_strobes", {ram_wren, ram_rden, apb_pready}, 3'b000);
        @(posedge apb_clock); #1;
        chk("abort_state_idle", dut.state_q, ST_IDLE);
        chk("abort_proto_err", proto_err, 1'b1);
        @(negedge apb_clock);
        chk("abort_t3_strobes", {ram_wren, ram_rden, apb_pready}, 3'b000);
        @(posedge apb_clock); #1;
        apb_xfer(1'b0, 32'h20, 32'h0, 4'h0, 3'b000);
        chk("after_abort_rdata", got_rdata, 32'hAA22CC44);
        chk("after_abort_ready", rdy_cyc, 5);
        chk("err_count_kept", err_count, 16'd3);

        // Reset while the read strobe is up (T3).
        apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b0;
        apb_paddr = 32'h10; apb_pprot = 3'b000;
        @(posedge apb_clock); #1;
        apb_penable = 1'b1;
        repeat (2) begin
            @(posedge apb_clock); #1;
        end
        @(negedge apb_clock);
        chk("midread_rden", ram_rden, 1'b1);
        resetn = 1'b0;
        #1;
        chk("midread_rst_apb", {apb_pready, apb_pslverr, apb_prdata}, 64'h0);
        chk("midread_rst_ram", {ram_wren, ram_rden, ram_addr, ram_byteena, ram_data}, 64'h0);
        chk("midread_rst_status", {err_count, proto_err}, 64'h0);
        chk("midread_rst_state", dut.state_q, ST_IDLE);
        apb_psel = 1'b0; apb_penable = 1'b0;
        @(posedge apb_clock); #1;
        resetn = 1'b1;
        @(posedge apb_clock); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
